// File: rtl/uart_tx_fifo_if.sv
// Host-side and driver-side signal bundle for the UART transmit FIFO.
// The master modport is the host/driver view; the slave modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          UART_Ready;
    logic          UART_Busy;
    logic          UART_Start;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_active;

    modport master (
        output wr_en,
        output wr_data,
        output clr_ovf,
        output UART_Ready,
        output UART_Busy,
        input  UART_Start,
        input  tx_data,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  tx_active
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  clr_ovf,
        input  UART_Ready,
        input  UART_Busy,
        output UART_Start,
        output tx_data,
        output full,
        output empty,
        output count,
        output overflow,
        output tx_active
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART driver: host writes bytes, an FSM pops one per
// driver Busy episode and strobes UART_Start with the byte on tx_data.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic drop;
    logic pop;

    // Full and empty come from the occupancy count only; the pointers wrap freely.
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        push  = bus.wr_en && !full;
        drop  = bus.wr_en && full;
        pop   = (state_q == IDLE) && !empty && bus.UART_Ready;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = mem_q[rd_ptr_q];
        end

        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end

        // A dropped write takes priority over a clear on the same edge.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.UART_Busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.UART_Busy && bus.UART_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage is deliberately left out of reset; stale bytes are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.UART_Start = (state_q == LOAD);
    assign bus.tx_active  = (state_q != IDLE);
    assign bus.tx_data    = tx_data_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based model predicts every
// output each cycle, and a simple driver model answers Start with Busy.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_tx;
    bit         m_ovf;
    bit         m_open;
    bit         m_start;
    bit         m_seen;

    bit hold_ready;
    int busy_len  = 4;
    int ready_lag = 0;
    bit drv_engaged;
    int drv_delay;
    int drv_busy_left;
    int drv_lag;

    logic [7:0] rx_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("count",     32'(bus.count),      32'(m_q.size()));
        check("full",      32'(bus.full),       32'(m_q.size() == DEPTH));
        check("empty",     32'(bus.empty),      32'(m_q.size() == 0));
        check("overflow",  32'(bus.overflow),   32'(m_ovf));
        check("start",     32'(bus.UART_Start), 32'(m_start));
        check("tx_active", 32'(bus.tx_active),  32'(m_open));
        check("tx_data",   32'(bus.tx_data),    32'(m_tx));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tx    = 8'h00;
        m_ovf   = 1'b0;
        m_open  = 1'b0;
        m_start = 1'b0;
        m_seen  = 1'b0;
        drv_engaged   = 1'b0;
        drv_delay     = 0;
        drv_busy_left = 0;
        drv_lag       = 0;
        bus.UART_Busy  = 1'b0;
        bus.UART_Ready = !hold_ready;
        rx_log.delete();
    endtask

    // Driver: Busy rises 3 cycles after a Start, lasts busy_len cycles, Ready returns ready_lag cycles later.
    task automatic drive_driver();
        if (bus.UART_Start) begin
            drv_engaged = 1'b1;
            drv_delay   = 3;
        end else if (drv_engaged && drv_delay > 0) begin
            drv_delay--;
            if (drv_delay == 0) begin
                drv_busy_left = busy_len;
                drv_lag       = ready_lag;
            end
        end
        bus.UART_Busy = (drv_busy_left > 0);
        if (drv_busy_left > 0) begin
            drv_busy_left--;
        end else if (drv_engaged && drv_delay == 0) begin
            if (drv_lag > 0) drv_lag--;
            else drv_engaged = 1'b0;
        end
        bus.UART_Ready = !hold_ready && !drv_engaged;
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] data, input bit clr);
        bit push, drop, pop;
        bit n_open, n_seen;
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.clr_ovf = clr;
        drive_driver();

        push   = wr && (m_q.size() < DEPTH);
        drop   = wr && (m_q.size() == DEPTH);
        pop    = !m_open && (m_q.size() > 0) && bus.UART_Ready;
        n_open = m_open;
        n_seen = m_seen;
        if (pop) begin
            n_open = 1'b1;
            n_seen = 1'b0;
        end else if (m_start) begin
            n_seen = 1'b0;
        end else if (m_open && !m_seen) begin
            n_seen = bus.UART_Busy;
        end else if (m_open && m_seen && !bus.UART_Busy && bus.UART_Ready) begin
            n_open = 1'b0;
        end

        @(posedge clk);
        if (pop) m_tx = m_q.pop_front();
        if (push) m_q.push_back(data);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_start = pop;
        m_open  = n_open;
        m_seen  = n_seen;

        @(negedge clk);
        checkOutput();
        if (bus.UART_Start) rx_log.push_back(bus.tx_data);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((m_q.size() != 0 || m_open) && n < max_cycles) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(m_q.size() != 0 || m_open), 32'd0);
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.clr_ovf    = 1'b0;
        bus.UART_Ready = 1'b0;
        bus.UART_Busy  = 1'b0;
        hold_ready     = 1'b0;
        rst            = 1'b1;
        model_reset();

        #1;
        check("rst_count",     32'(bus.count),      32'd0);
        check("rst_empty",     32'(bus.empty),      32'd1);
        check("rst_full",      32'(bus.full),       32'd0);
        check("rst_overflow",  32'(bus.overflow),   32'd0);
        check("rst_start",     32'(bus.UART_Start), 32'd0);
        check("rst_tx_data",   32'(bus.tx_data),    32'h00);
        check("rst_tx_active", 32'(bus.tx_active),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single byte");
        busy_len = 4; ready_lag = 0;
        rx_log.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        check("single_count_after_write", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        check("single_start_latency", 32'(bus.UART_Start), 32'd1);
        check("single_tx_data",       32'(bus.tx_data),    32'hA5);
        drain(100);
        check("single_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) check("single_rx_byte", 32'(rx_log[0]), 32'hA5);
        check("single_empty", 32'(bus.empty), 32'd1);
        check("single_count", 32'(bus.count), 32'd0);

        $display("[TB] fill and overflow");
        rx_log.delete();
        hold_ready = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        check("fill_overflow", 32'(bus.overflow), 32'd1);
        check("fill_count_17", 32'(bus.count),    32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        check("ovf_clear", 32'(bus.overflow), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        check("ovf_set_wins", 32'(bus.overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        hold_ready = 1'b0;
        applyStimulus(1'b1, 8'hDD, 1'b0);
        check("drop_with_pop_count", 32'(bus.count),    32'd15);
        check("drop_with_pop_ovf",   32'(bus.overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        drain(400);
        check("fill_rx_count", 32'(rx_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++) check("fill_order", 32'(rx_log[i]), 32'(i));

        $display("[TB] long busy handshake");
        rx_log.delete();
        busy_len = 100; ready_lag = 2;
        hold_ready = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        hold_ready = 1'b0;
        drain(1000);
        check("hs_rx_count", 32'(rx_log.size()), 32'd3);
        if (rx_log.size() == 3) begin
            check("hs_rx0", 32'(rx_log[0]), 32'h11);
            check("hs_rx1", 32'(rx_log[1]), 32'h22);
            check("hs_rx2", 32'(rx_log[2]), 32'h33);
        end

        $display("[TB] simultaneous write and pop");
        rx_log.delete();
        busy_len = 2; ready_lag = 0;
        hold_ready = 1'b1;
        applyStimulus(1'b1, 8'h44, 1'b0);
        hold_ready = 1'b0;
        applyStimulus(1'b1, 8'h55, 1'b0);
        check("simul_count",   32'(bus.count),      32'd1);
        check("simul_start",   32'(bus.UART_Start), 32'd1);
        check("simul_tx_data", 32'(bus.tx_data),    32'h44);
        drain(200);
        check("simul_rx_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() == 2) begin
            check("simul_rx0", 32'(rx_log[0]), 32'h44);
            check("simul_rx1", 32'(rx_log[1]), 32'h55);
        end

        $display("[TB] wrap with 40 bytes");
        rx_log.delete();
        begin
            int sent = 0;
            int n = 0;
            while ((sent < 40 || m_q.size() != 0 || m_open) && n < 3000) begin
                if (sent < 40 && m_q.size() < DEPTH) begin
                    applyStimulus(1'b1, 8'(sent), 1'b0);
                    sent++;
                end else begin
                    applyStimulus(1'b0, 8'h00, 1'b0);
                end
                n++;
            end
            check("wrap_timeout", 32'(n >= 3000), 32'd0);
        end
        check("wrap_rx_count", 32'(rx_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx_log.size(); i++) check("wrap_order", 32'(rx_log[i]), 32'(i));

        $display("[TB] reset during transfer");
        busy_len = 100; ready_lag = 0;
        hold_ready = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
        hold_ready = 1'b0;
        begin
            int n = 0;
            while (!(m_open && m_seen) && n < 50) begin
                applyStimulus(1'b0, 8'h00, 1'b0);
                n++;
            end
            check("reach_wait_done", 32'(m_open && m_seen), 32'd1);
        end
        check("pre_reset_count", 32'(bus.count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count",     32'(bus.count),      32'd0);
        check("midrst_start",     32'(bus.UART_Start), 32'd0);
        check("midrst_tx_active", 32'(bus.tx_active),  32'd0);
        check("midrst_empty",     32'(bus.empty),      32'd1);
        bus.wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        busy_len = 4;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        drain(100);
        check("post_reset_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) check("post_reset_first", 32'(rx_log[0]), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; must be a power of two, at least 2.
REQ-002 SHALL have localparam AW = log2(DEPTH), the pointer width.
REQ-003 SHALL have port clk, input, 1 bit: the one system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write request from the host.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port clr_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-008 SHALL have port UART_Ready, input, 1 bit: the UART driver can accept a byte.
REQ-009 SHALL have port UART_Busy, input, 1 bit: the UART driver is transmitting.
REQ-010 SHALL have port UART_Start, output, 1 bit: one-cycle launch strobe to the driver.
REQ-011 SHALL have port tx_data, output, 8 bits: byte presented to the driver's data_in.
REQ-012 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 SHALL have port empty, output, 1 bit: count == 0.
REQ-014 SHALL have port count, output, AW+1 bits: number of stored bytes.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, a write was dropped.
REQ-016 SHALL have port tx_active, output, 1 bit: the FSM is not IDLE.

Function
REQ-017 SHALL accept a write at a rising edge when wr_en=1 and full=0 (registered): store at wr_ptr, then wr_ptr+1 modulo DEPTH.
REQ-018 SHALL drop a write when wr_en=1 and full=1, leave contents and count unchanged, and set overflow, even if a pop occurs on the same edge.
REQ-019 SHALL clear overflow on clr_ovf=1; if clr_ovf and a dropped write coincide, set wins.
REQ-020 SHALL let pointers wrap silently; count alone SHALL distinguish full from empty.
REQ-021 SHALL update count on a simultaneous accepted write and pop as follows: count unchanged, both pointers advance.
REQ-022 SHALL use an FSM with states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE -> LOAD SHALL occur when empty=0 and UART_Ready=1; on that edge:
- the head byte is popped into tx_data;
- rd_ptr increments;
- count decrements.
REQ-024 LOAD SHALL drive UART_Start=1 for exactly one cycle, then go to WAIT_BUSY unconditionally.
REQ-025 WAIT_BUSY -> WAIT_DONE SHALL occur when UART_Busy=1.
REQ-026 WAIT_DONE -> IDLE SHALL occur when UART_Busy=0 and UART_Ready=1.
REQ-027 UART_Start SHALL be 0 in every state except LOAD.
REQ-028 tx_data SHALL hold stable from LOAD through WAIT_DONE and change only on a pop.
REQ-029 Latency: a write accepted at edge k into an empty FIFO, with UART_Ready=1 and the FSM in IDLE, SHALL pop at edge k+1, with UART_Start high for the cycle between edges k+1 and k+2.
REQ-030 Bytes SHALL leave in write order, with no loss or duplication.
REQ-031 The FSM SHALL start at most one byte per driver Busy episode.

Reset
REQ-032 rst=1 SHALL asynchronously force:
- state IDLE;
- wr_ptr=0, rd_ptr=0, count=0;
- empty=1, full=0;
- overflow=0, UART_Start=0, tx_data=8'h00, tx_active=0.
REQ-033 Reset mid-transfer SHALL discard all queued bytes; RAM contents need not be cleared.
REQ-034 The first byte written after reset release SHALL be the first byte sent.

Verification
REQ-035 Single byte: write 8'hA5 into an empty FIFO with Ready=1 -> UART_Start pulses once with tx_data=8'hA5, count returns 0, empty=1.
REQ-036 Fill: 16 writes with Ready=0 -> full=1, count=16; a 17th write (8'hFF) -> overflow=1, and the 16 bytes later emerge 0..15 in order.
REQ-037 Driver handshake: the model asserts Busy 3 cycles after Start and holds it 100 cycles -> no second Start until Busy falls and Ready=1.
REQ-038 Simultaneous write and pop at count=1 -> count stays 1, order preserved.
REQ-039 Wrap: 40 bytes streamed through a DEPTH=16 FIFO -> all 40 received in order, pointers wrap without error.
REQ-040 Reset asserted during WAIT_DONE with 5 bytes queued -> immediately count=0, UART_Start=0, tx_active=0; the next written byte is sent first.
